// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//
// Memory-access stage of the RV64 in-order pipeline. It sits between the
// execute-to-memory register and the memory-to-writeback register.
//
// Each instruction performs at most one load or store over a valid/ready
// data bus. Load data is aligned and extended here. The stage presents a
// registered result to writeback, and holds `stall` high while a bus
// transaction is outstanding.
//
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   in_*                 : instruction fields from the execute stage
//   dreq_*               : data-bus request (valid, addr, size, strobe, data)
//   dresp_*              : data-bus response (addr_ok, data_ok, read data)
//   stall                : stage busy, upstream must hold
//   out_valid/pc/result  : registered result towards writeback
//   misalign             : registered misaligned-access flag
// ---------------------------------------------------------------------------
module memory_stage #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [63:0]       in_pc,
  input  logic [63:0]       in_alu_out,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [1:0]        in_msize,
  input  logic              in_mem_unsigned,
  input  logic [63:0]       in_store_data,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [63:0]       dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [63:0]       dresp_data,
  output logic              stall,
  output logic              out_valid,
  output logic [63:0]       out_pc,
  output logic [63:0]       out_result,
  output logic              misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e state_q, state_d;

  // Request registers: they drive the bus directly, so the request stays
  // stable for as long as the FSM sits in REQ.
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [1:0]        req_size_q, req_size_d;
  logic [7:0]        req_strobe_q, req_strobe_d;
  logic [63:0]       req_data_q, req_data_d;
  logic              req_unsigned_q, req_unsigned_d;
  logic              req_is_load_q, req_is_load_d;
  logic [63:0]       req_pc_q, req_pc_d;

  logic              out_valid_q, out_valid_d;
  logic [63:0]       out_pc_q, out_pc_d;
  logic [63:0]       out_result_q, out_result_d;
  logic              misalign_q, misalign_d;

  logic              is_mem;
  logic              addr_mis;
  logic              accept;
  logic              finish;
  logic [7:0]        size_mask;
  logic [63:0]       load_shifted;
  logic [63:0]       load_ext;

  // ---------------- decode of the incoming instruction ----------------
  assign is_mem = in_mem_read | in_mem_write;
  assign accept = (state_q == S_IDLE) && in_valid;

  always_comb begin
    addr_mis  = 1'b0;
    size_mask = 8'h01;
    case (in_msize)
      2'd0: begin addr_mis = 1'b0;              size_mask = 8'h01; end
      2'd1: begin addr_mis = in_alu_out[0];     size_mask = 8'h03; end
      2'd2: begin addr_mis = |in_alu_out[1:0];  size_mask = 8'h0F; end
      default: begin addr_mis = |in_alu_out[2:0]; size_mask = 8'hFF; end
    endcase
  end

  // A response completes the instruction either together with the address
  // handshake in REQ, or on its own in WAIT. A data_ok in IDLE, or in REQ
  // without addr_ok, does not complete anything.
  assign finish = ((state_q == S_REQ) && dresp_addr_ok && dresp_data_ok) ||
                  ((state_q == S_WAIT) && dresp_data_ok);

  // ---------------- load alignment and extension ----------------
  assign load_shifted = dresp_data >> {req_addr_q[2:0], 3'b000};

  always_comb begin
    load_ext = load_shifted;
    case (req_size_q)
      2'd0: load_ext = req_unsigned_q ? {56'd0, load_shifted[7:0]}
                                      : {{56{load_shifted[7]}}, load_shifted[7:0]};
      2'd1: load_ext = req_unsigned_q ? {48'd0, load_shifted[15:0]}
                                      : {{48{load_shifted[15]}}, load_shifted[15:0]};
      2'd2: load_ext = req_unsigned_q ? {32'd0, load_shifted[31:0]}
                                      : {{32{load_shifted[31]}}, load_shifted[31:0]};
      default: load_ext = load_shifted;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && is_mem && !addr_mis) state_d = S_REQ;
      S_REQ:  if (dresp_addr_ok) state_d = dresp_data_ok ? S_IDLE : S_WAIT;
      S_WAIT: if (dresp_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    dreq_valid = 1'b0;
    stall      = 1'b0;
    case (state_q)
      S_REQ:  begin dreq_valid = 1'b1; stall = 1'b1; end
      S_WAIT: begin dreq_valid = 1'b0; stall = ~dresp_data_ok; end
      default: begin dreq_valid = 1'b0; stall = 1'b0; end
    endcase
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    req_addr_d     = req_addr_q;
    req_size_d     = req_size_q;
    req_strobe_d   = req_strobe_q;
    req_data_d     = req_data_q;
    req_unsigned_d = req_unsigned_q;
    req_is_load_d  = req_is_load_q;
    req_pc_d       = req_pc_q;
    out_valid_d    = 1'b0;
    out_pc_d       = out_pc_q;
    out_result_d   = out_result_q;
    misalign_d     = 1'b0;

    if (accept) begin
      if (!is_mem || addr_mis) begin
        // Completes in one cycle without touching the bus.
        out_valid_d  = 1'b1;
        out_pc_d     = in_pc;
        out_result_d = is_mem ? 64'd0 : in_alu_out;
        misalign_d   = is_mem;
      end else begin
        req_addr_d     = in_alu_out[ADDR_W-1:0];
        req_size_d     = in_msize;
        req_strobe_d   = in_mem_write ? (size_mask << in_alu_out[2:0]) : 8'h00;
        req_data_d     = in_store_data << {in_alu_out[2:0], 3'b000};
        req_unsigned_d = in_mem_unsigned;
        req_is_load_d  = in_mem_read;
        req_pc_d       = in_pc;
      end
    end

    if (finish) begin
      out_valid_d  = 1'b1;
      out_pc_d     = req_pc_q;
      out_result_d = req_is_load_q ? load_ext : 64'(req_addr_q);
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_addr_q     <= '0;
      req_size_q     <= 2'd0;
      req_strobe_q   <= 8'h00;
      req_data_q     <= 64'd0;
      req_unsigned_q <= 1'b0;
      req_is_load_q  <= 1'b0;
      req_pc_q       <= 64'd0;
      out_valid_q    <= 1'b0;
      out_pc_q       <= 64'd0;
      out_result_q   <= 64'd0;
      misalign_q     <= 1'b0;
    end else begin
      req_addr_q     <= req_addr_d;
      req_size_q     <= req_size_d;
      req_strobe_q   <= req_strobe_d;
      req_data_q     <= req_data_d;
      req_unsigned_q <= req_unsigned_d;
      req_is_load_q  <= req_is_load_d;
      req_pc_q       <= req_pc_d;
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_result_q   <= out_result_d;
      misalign_q     <= misalign_d;
    end
  end

  assign dreq_addr   = req_addr_q;
  assign dreq_size   = req_size_q;
  assign dreq_strobe = req_strobe_q;
  assign dreq_data   = req_data_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_result  = out_result_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage
//
// Directed bench for memory_stage. Stimulus pushes the expected writeback
// result (pc, result, misalign, cycle) into a scoreboard queue. A separate
// monitor pops and compares whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_memory_stage;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [63:0] in_alu_out;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [1:0]  in_msize;
  logic        in_mem_unsigned;
  logic [63:0] in_store_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        stall;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_result;
  logic        misalign;

  memory_stage #(.ADDR_W(64)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_pc(in_pc), .in_alu_out(in_alu_out),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_msize(in_msize), .in_mem_unsigned(in_mem_unsigned),
    .in_store_data(in_store_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data),
    .stall(stall), .out_valid(out_valid), .out_pc(out_pc),
    .out_result(out_result), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] res;
    logic        mis;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
    end
  endtask

  // The expected result appears on the next rising edge.
  task automatic push(input logic [63:0] pc, input logic [63:0] res, input logic mis);
    exp_t e;
    e.pc  = pc;
    e.res = res;
    e.mis = mis;
    e.cyc = cycle + 1;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] pc, input logic [63:0] alu, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] sd);
    in_valid        = 1'b1;
    in_pc           = pc;
    in_alu_out      = alu;
    in_mem_read     = rd;
    in_mem_write    = wr;
    in_msize        = sz;
    in_mem_unsigned = uns;
    in_store_data   = sd;
  endtask

  task automatic idle_in();
    in_valid     = 1'b0;
    in_mem_read  = 1'b0;
    in_mem_write = 1'b0;
  endtask

  // Load with addr_ok in the first REQ cycle and data_ok two cycles later.
  task automatic load_slow(input logic [63:0] pc, input logic [63:0] addr, input logic [1:0] sz,
                           input logic uns, input logic [63:0] rdata, input logic [63:0] exp);
    issue(pc, addr, 1'b1, 1'b0, sz, uns, 64'd0);
    step();
    idle_in();
    dresp_addr_ok = 1'b1;
    #1;
    chk("ld_req_valid", {63'd0, dreq_valid}, 64'd1);
    chk("ld_req_addr", dreq_addr, addr);
    chk("ld_req_strobe", {56'd0, dreq_strobe}, 64'd0);
    chk("ld_stall_req", {63'd0, stall}, 64'd1);
    step();
    dresp_addr_ok = 1'b0;
    #1;
    chk("ld_wait_valid", {63'd0, dreq_valid}, 64'd0);
    chk("ld_stall_wait", {63'd0, stall}, 64'd1);
    step();
    dresp_data_ok = 1'b1;
    dresp_data    = rdata;
    push(pc, exp, 1'b0);
    #1;
    chk("ld_stall_done", {63'd0, stall}, 64'd0);
    step();
    dresp_data_ok = 1'b0;
  endtask

  // Load with addr_ok and data_ok together in the first REQ cycle.
  task automatic load_fast(input logic [63:0] pc, input logic [63:0] addr, input logic [1:0] sz,
                           input logic uns, input logic [63:0] rdata, input logic [63:0] exp);
    issue(pc, addr, 1'b1, 1'b0, sz, uns, 64'd0);
    step();
    idle_in();
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = rdata;
    push(pc, exp, 1'b0);
    step();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (resetn && out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: out_valid=1 pc=0x%h result=0x%h, required no output",
                 out_pc, out_result);
      end else begin
        e = sb.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_result", out_result, e.res);
        chk("out_misalign", {63'd0, misalign}, {63'd0, e.mis});
        chk("out_cycle", 64'(cycle), 64'(e.cyc));
      end
    end
  end

  initial begin
    resetn          = 1'b0;
    idle_in();
    in_pc           = 64'd0;
    in_alu_out      = 64'd0;
    in_msize        = 2'd0;
    in_mem_unsigned = 1'b0;
    in_store_data   = 64'd0;
    dresp_addr_ok   = 1'b0;
    dresp_data_ok   = 1'b0;
    dresp_data      = 64'd0;

    // Reset state
    step();
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_misalign", {63'd0, misalign}, 64'd0);
    chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("rst_dreq_strobe", {56'd0, dreq_strobe}, 64'd0);
    chk("rst_dreq_addr", dreq_addr, 64'd0);
    chk("rst_dreq_data", dreq_data, 64'd0);
    chk("rst_dreq_size", {62'd0, dreq_size}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    resetn = 1'b1;
    step();

    // ALU-only stream
    issue(64'h8000_0000, 64'h1234, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0);
    push(64'h8000_0000, 64'h1234, 1'b0);
    #1 chk("alu_stall0", {63'd0, stall}, 64'd0);
    step();
    issue(64'h8000_0004, 64'h5678, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0);
    push(64'h8000_0004, 64'h5678, 1'b0);
    #1 chk("alu_stall1", {63'd0, stall}, 64'd0);
    step();
    idle_in();
    step();

    // Load byte at 0x1003, signed then unsigned
    load_slow(64'h100, 64'h1003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    load_slow(64'h104, 64'h1003, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);

    // Store half at 0x2006
    issue(64'h200, 64'h2006, 1'b0, 1'b1, 2'd1, 1'b0, 64'hABCD);
    step();
    idle_in();
    #1;
    chk("sth_valid", {63'd0, dreq_valid}, 64'd1);
    chk("sth_strobe", {56'd0, dreq_strobe}, 64'hC0);
    chk("sth_data", dreq_data, 64'hABCD_0000_0000_0000);
    chk("sth_size", {62'd0, dreq_size}, 64'd1);
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    push(64'h200, 64'h2006, 1'b0);
    step();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    #1;
    chk("sth_idle_valid", {63'd0, dreq_valid}, 64'd0);
    chk("sth_idle_stall", {63'd0, stall}, 64'd0);

    // Misaligned word load
    issue(64'h300, 64'h2002, 1'b1, 1'b0, 2'd2, 1'b0, 64'd0);
    push(64'h300, 64'd0, 1'b1);
    step();
    idle_in();
    #1;
    chk("mis_no_req", {63'd0, dreq_valid}, 64'd0);
    chk("mis_stall", {63'd0, stall}, 64'd0);
    step();

    // Extra extension cases
    load_fast(64'h400, 64'h4004, 2'd2, 1'b0, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF);
    load_fast(64'h404, 64'h4002, 2'd1, 1'b0, 64'h0000_0000_7FFF_0000, 64'h0000_0000_0000_7FFF);
    load_fast(64'h408, 64'h4008, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    // Bus backpressure: store word at 0x3004, addr_ok low for 5 cycles
    issue(64'h500, 64'h3004, 1'b0, 1'b1, 2'd2, 1'b0, 64'h1122_3344);
    step();
    idle_in();
    for (int i = 0; i < 5; i++) begin
      dresp_data_ok = (i == 2); // lone data_ok in REQ must be ignored
      #1;
      chk("bp_valid", {63'd0, dreq_valid}, 64'd1);
      chk("bp_addr", dreq_addr, 64'h3004);
      chk("bp_strobe", {56'd0, dreq_strobe}, 64'hF0);
      chk("bp_data", dreq_data, 64'h1122_3344_0000_0000);
      chk("bp_stall", {63'd0, stall}, 64'd1);
      step();
    end
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    push(64'h500, 64'h3004, 1'b0);
    step();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    step();

    // Reset while in WAIT
    issue(64'h600, 64'h5000, 1'b1, 1'b0, 2'd3, 1'b0, 64'd0);
    step();
    idle_in();
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    #1 chk("rw_in_wait_stall", {63'd0, stall}, 64'd1);
    resetn = 1'b0;
    #1;
    chk("rw_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rw_out_pc", out_pc, 64'd0);
    chk("rw_out_result", out_result, 64'd0);
    chk("rw_misalign", {63'd0, misalign}, 64'd0);
    chk("rw_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("rw_dreq_addr", dreq_addr, 64'd0);
    chk("rw_dreq_strobe", {56'd0, dreq_strobe}, 64'd0);
    chk("rw_dreq_size", {62'd0, dreq_size}, 64'd0);
    chk("rw_stall", {63'd0, stall}, 64'd0);
    step();
    resetn = 1'b1;
    step();
    dresp_data_ok = 1'b1;
    dresp_data    = 64'hDEAD_BEEF_DEAD_BEEF;
    #1 chk("late_dok_stall", {63'd0, stall}, 64'd0);
    step();
    dresp_data_ok = 1'b0;
    #1 chk("late_dok_out_valid", {63'd0, out_valid}, 64'd0);
    step();
    step();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline memory-access stage between the execute-to-memory register and the memory-to-writeback register of the RV64 in-order core. It takes the ALU result and control bits produced by execute, performs at most one load or store per instruction over a valid/ready data-bus handshake, aligns and extends load data, and presents a registered result to writeback. While a bus transaction is outstanding it raises `stall` so that upstream stages hold.

## Interface
Parameters:
- `ADDR_W`, default 64: data-bus address width.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: an instruction is present from the execute-to-memory register.
- `in_pc`  in  64: PC of the instruction.
- `in_alu_out`  in  64: ALU result; effective address for memory operations.
- `in_mem_read`, `in_mem_write`  in  1 each: load or store; never both high together.
- `in_msize`  in  2: 0 = byte, 1 = half, 2 = word, 3 = double.
- `in_mem_unsigned`  in  1: zero-extend the load when high, sign-extend when low.
- `in_store_data`  in  64: store value, right-aligned.
- `dreq_valid`  out  1: bus request valid.
- `dreq_addr`  out  ADDR_W: request address.
- `dreq_size`  out  2: request size, same encoding as `in_msize`.
- `dreq_strobe`  out  8: byte-write enables; all zero for loads.
- `dreq_data`  out  64: store data, lane-shifted.
- `dresp_addr_ok`  in  1: bus has accepted the request.
- `dresp_data_ok`  in  1: response or write-complete is available.
- `dresp_data`  in  64: read data, naturally lane-aligned.
- `stall`  out  1: this stage cannot accept a new instruction this cycle.
- `out_valid`  out  1: registered result valid to writeback.
- `out_pc`  out  64: registered PC.
- `out_result`  out  64: registered ALU result or extended load data.
- `misalign`  out  1: registered flag set alongside `out_valid` when the access was misaligned.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE with `in_valid`:
  - If the instruction is not a memory operation, or the address is misaligned (`addr[msize-1:0]` ≠ 0 for msize > 0), capture it to the output registers next edge. For a non-memory op, `out_result` = `in_alu_out`. For a misaligned access, `out_result` = 0, `misalign` = 1, and no bus request is issued.
  - Otherwise, latch address, size, strobe, data and extension mode into request registers and go to REQ.
- REQ: `dreq_valid` = 1 with the latched fields.
  - On `dresp_addr_ok` without `dresp_data_ok`, go to WAIT.
  - On `dresp_addr_ok` and `dresp_data_ok` in the same cycle, finish and go to IDLE.
- WAIT: `dreq_valid` = 0. On `dresp_data_ok`, finish and go to IDLE.
- `dresp_data_ok` in IDLE, or in REQ without `dresp_addr_ok`, is ignored.
- Finish: in the same edge, `out_valid` = 1, `out_pc` = latched PC, and `out_result` as follows:
  - Loads: the selected byte lane(s) of `dresp_data`, shifted right by `addr[2:0]`·8, then sign- or zero-extended to 64 bits.
  - Stores: `out_result` = the latched address.
- Store strobe is the size mask shifted left by `addr[2:0]`: 0x01, 0x03, 0x0F or 0xFF. `dreq_data` = `in_store_data` shifted left by `addr[2:0]`·8, truncated to 64 bits.
- `stall` = 1 in REQ, and in WAIT unless `dresp_data_ok` is high this cycle. `stall` = 0 in IDLE.
- `out_valid` = 0 on any edge that does not capture or finish an instruction.
- Reset mid-transaction: the FSM returns to IDLE and the in-flight response is dropped. The bus is reset together with the core.

## Timing
- Reset values: state IDLE, `dreq_valid` 0, `dreq_strobe` 0, `dreq_addr`/`dreq_data`/`dreq_size` 0, `stall` 0, `out_valid` 0, `out_pc` 0, `out_result` 0, `misalign` 0.
- Latency:
  - Non-memory or misaligned instruction: 1 cycle.
  - Memory op: 1 cycle to enter REQ, plus the bus wait cycles, plus 1 edge to the output. Minimum 2 cycles with an immediate `addr_ok` and `data_ok`.
- Request fields stay stable while `dreq_valid` is high until `dresp_addr_ok` is seen.
- Back-to-back: a new instruction is accepted in the same cycle the FSM returns to IDLE (the edge after finish).
- Throughput for non-memory instructions: 1 per cycle.

## Test plan
- ALU-only stream: `in_valid`=1 with pc 0x80000000 and alu_out 0x1234, then pc 0x80000004 and alu_out 0x5678, on consecutive cycles → `out_result` shows 0x1234 and then 0x5678 one cycle later each; `stall` stays 0.
- Load byte, signed: addr 0x1003, `dresp_data` 0x00000000_80000000, with `addr_ok` one cycle and `data_ok` two cycles after the request → `out_result` 0xFFFFFFFF_FFFFFF80, `stall` high for 2 cycles. The same access with `in_mem_unsigned`=1 → `out_result` 0x80.
- Store half: addr 0x2006, data 0xABCD → `dreq_strobe` 0xC0, `dreq_data` 0xABCD0000_00000000. `addr_ok` and `data_ok` in the same cycle → finish in 2 cycles.
- Misaligned word load at 0x2002 → no `dreq_valid`, `misalign`=1, `out_result`=0 after 1 cycle.
- Bus backpressure: `addr_ok` held low for 5 cycles → `dreq_addr`, `dreq_strobe` and `dreq_data` stay constant and `stall` stays high throughout. Then issue `addr_ok` and `data_ok` → completes correctly.
- Assert `resetn` low while in WAIT → all outputs return to their reset values immediately. A `data_ok` arriving after reset deasserts → ignored.
